stack_alu: RTL and testbench
============================

Name: stack_alu

Overview:
- Parametrised operand stack with an integrated ALU. It is the next generation of the team's fixed stack block: configurable width and depth, arithmetic, logic and stack-manipulation ops, and overflow/underflow error reporting.
- Sits between the command decoder and the result bus.
- Executes one op per clock while apply is high. The top of stack is always visible on head.

Parameters:
- W, 16, data width in bits (≥2).
- DEPTH, 8, number of stack entries (≥2).
- CW, $clog2(DEPTH+1), width of the count output. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in  in  W  operand for PUSH.
- op  in  4  opcode, sampled when apply=1.
- apply  in  1  level-sensitive; one op executes per rising edge while high.
- head  out  W  top-of-stack value, registered.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- valid  out  1  count>0 and the last applied op raised no error.
- count  out  CW  number of stored entries.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow/illegal-op flag.

Behaviour:
- Reset: rst=0 forces head=0, count=0, ovf=0, udf=0, valid=0, empty=1, full=0 immediately, without waiting for clk.
  - Reset mid-operation aborts the op; no partial state survives.
  - Storage array contents are don't-care after reset.
- Timing:
  - op is sampled at a rising edge with apply=1.
  - head, count and flags reflect the op after that same edge (1-cycle latency).
  - apply=0: full state hold, including valid; in and op are ignored.
- Notation: T = top, S = second. "pop2 push X" consumes T and S and pushes X; net count −1.
- Opcodes:
  - 0 NOP: no change.
  - 1 ADD: pop2 push S+T.
  - 2 SUB: pop2 push S−T.
  - 3 MUL: pop2 push low W bits of S*T.
  - 4 AND, 5 OR, 6 XOR: pop2 push bitwise result.
  - 7 PUSH: push in.
  - 8 POP: remove T.
  - 9 DUP: push T.
  - 10 SWAP: exchange T and S.
  - 11 OVER: push S.
  - 12 CLEAR: count=0, head=0, ovf=0, udf=0.
  - 13–15: illegal.
- Arithmetic: two's-complement, modulo 2^W wrap (unless the optional feature below is compiled in). No carry output.
- Errors: the op is not executed and stack contents, count and head are unchanged.
  - Overflow: PUSH, DUP or OVER while full sets ovf.
  - Underflow: POP with count<1 sets udf.
  - Underflow: DUP with count<1 sets udf.
  - Underflow: binary ALU ops, SWAP or OVER with count<2 set udf.
  - Illegal opcode sets udf.
  - An erroring op clears valid. The next successful op re-asserts valid if count>0.
- Flags: ovf and udf stay set until CLEAR or reset.
- head after an op that empties the stack: 0.
- head after POP: the new top is presented on the next cycle; no bubble.
- Storage: top held in a dedicated register driving head; remaining entries in an array indexed by count−2. Both update on the same edge.
- Back-to-back ops every cycle must work with no stall.

Optional Feature:
- Macro: STACK_ALU_SAT_EN.
- Defined: ADD, SUB and MUL saturate as signed values.
  - Positive overflow gives 2^(W−1)−1.
  - Negative overflow gives −2^(W−1).
  - ovf is not set by saturation.
- Undefined: results wrap modulo 2^W, and the saturation logic is absent from the netlist.

Test Plan (W=16, DEPTH=4):
- Reset: rst=0 for 2 cycles → head=0, count=0, empty=1, valid=0, ovf=udf=0. Assert rst=0 mid-PUSH stream → count=0 immediately, before the next edge.
- PUSH/hold: op=7, apply=1, in=150 for one edge, then in=13 for one edge → head=150 then 13, count=2. Then apply=0, in=18 for 5 cycles → head stays 13 (head≠in every cycle).
- ALU: PUSH 10, PUSH 3, SUB → head=7, count=1. PUSH 5, ADD → head=12. PUSH 0x0100, MUL → head=0x0C00. PUSH 0x00FF, AND → head=0x0000.
- Stack ops: PUSH 1, PUSH 2, SWAP → head=1. OVER → head=2, count=3. DUP → head=2, count=4, full=1. POP → head=2, count=3.
- Errors: PUSH 11, 22, 33, 44, then 55 → ovf=1, valid=0, head=44, count=4. CLEAR, then ADD → udf=1, count=0. Opcode 14 → udf stays 1. CLEAR → ovf=udf=0.
- Saturation: PUSH 0x7FFF, PUSH 0x0001, ADD → head=0x8000 without STACK_ALU_SAT_EN, 0x7FFF with it. In both builds ovf=0.

Source files
------------

// File: rtl/stack_alu.sv
// Parametrised operand stack with integrated ALU; top of stack lives in a register driving head.
// Optional STACK_ALU_SAT_EN: ADD/SUB/MUL saturate as signed values instead of wrapping.
module stack_alu #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic [3:0]    op,
  input  logic          apply,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);
  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_MUL   = 4'd3,
                         OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR  = 4'd6,  OP_PUSH  = 4'd7,
                         OP_POP = 4'd8,  OP_DUP = 4'd9,  OP_SWAP = 4'd10, OP_OVER  = 4'd11,
                         OP_CLR = 4'd12;

  logic [W-1:0]  top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
  logic [W-1:0]  arr_q [DEPTH-1];

  logic          wr_en;
  logic [IW-1:0] wr_idx, t_idx, s_idx;
  logic [W-1:0]  wr_data, s_val, alu_res;
  logic          has1, has2, is_full, err;

`ifdef STACK_ALU_SAT_EN
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    r = a + b;
    if (a[W-1] == b[W-1] && r[W-1] != a[W-1]) r = a[W-1] ? MINV : MAXV;
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    r = a - b;
    if (a[W-1] != b[W-1] && r[W-1] != a[W-1]) r = a[W-1] ? MINV : MAXV;
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = a * b;
    // The product fits only if its upper W+1 bits are pure sign extension.
    if (p[2*W-1:W-1] != {(W+1){p[2*W-1]}}) return p[2*W-1] ? MINV : MAXV;
    return p[W-1:0];
  endfunction
`endif

  assign t_idx   = IW'(count_q - CW'(1));
  assign s_idx   = IW'(count_q - CW'(2));
  assign s_val   = arr_q[s_idx];
  assign has1    = (count_q != '0);
  assign has2    = (count_q >= CW'(2));
  assign is_full = (count_q == CW'(DEPTH));

  always_comb begin
    alu_res = '0;
    case (op)
`ifdef STACK_ALU_SAT_EN
      OP_ADD: alu_res = sat_add(s_val, top_q);
      OP_SUB: alu_res = sat_sub(s_val, top_q);
      OP_MUL: alu_res = sat_mul(s_val, top_q);
`else
      OP_ADD: alu_res = s_val + top_q;
      OP_SUB: alu_res = s_val - top_q;
      OP_MUL: alu_res = s_val * top_q;
`endif
      OP_AND: alu_res = s_val & top_q;
      OP_OR:  alu_res = s_val | top_q;
      OP_XOR: alu_res = s_val ^ top_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    valid_d = valid_q;
    wr_en   = 1'b0;
    wr_idx  = t_idx;
    wr_data = top_q;
    err     = 1'b0;
    if (apply) begin
      case (op)
        OP_NOP: ;
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
          if (!has2) begin err = 1'b1; udf_d = 1'b1; end
          else begin top_d = alu_res; count_d = count_q - CW'(1); end
        end
        OP_PUSH: begin
          if (is_full) begin err = 1'b1; ovf_d = 1'b1; end
          else begin
            wr_en   = has1;
            top_d   = in;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (!has1) begin err = 1'b1; udf_d = 1'b1; end
          else begin
            // The entry below the top moves up; an emptied stack shows zero.
            top_d   = has2 ? s_val : '0;
            count_d = count_q - CW'(1);
          end
        end
        OP_DUP: begin
          if (is_full)    begin err = 1'b1; ovf_d = 1'b1; end
          else if (!has1) begin err = 1'b1; udf_d = 1'b1; end
          else begin wr_en = 1'b1; count_d = count_q + CW'(1); end
        end
        OP_SWAP: begin
          if (!has2) begin err = 1'b1; udf_d = 1'b1; end
          else begin wr_en = 1'b1; wr_idx = s_idx; top_d = s_val; end
        end
        OP_OVER: begin
          if (is_full)    begin err = 1'b1; ovf_d = 1'b1; end
          else if (!has2) begin err = 1'b1; udf_d = 1'b1; end
          else begin wr_en = 1'b1; top_d = s_val; count_d = count_q + CW'(1); end
        end
        OP_CLR: begin
          top_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end
        default: begin err = 1'b1; udf_d = 1'b1; end
      endcase
      valid_d = !err && (count_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      valid_q <= valid_d;
    end
  end

  // Storage below the top needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en && rst) arr_q[wr_idx] <= wr_data;
  end

  assign head  = top_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = is_full;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;
endmodule

// File: tb/tb_stack_alu.sv
// Directed self-checking bench for stack_alu (W=16, DEPTH=4).
module tb_stack_alu;
  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din = '0;
  logic [3:0]    op = 4'd0;
  logic          apply = 1'b0;
  logic [W-1:0]  head;
  logic          empty, full, valid, ovf, udf;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  stack_alu #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(din), .op(op), .apply(apply),
    .head(head), .empty(empty), .full(full), .valid(valid),
    .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] d);
    op = o; din = d; apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] h, input int c);
    chk({tag, ".head"}, 32'(head), 32'(h));
    chk({tag, ".count"}, 32'(count), c);
  endtask

  initial begin
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.head", 32'(head), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.udf", 32'(udf), 0);
    rst = 1'b1;

    // PUSH then hold.
    do_op(4'd7, 16'd150);
    chk_state("push150", 16'd150, 1);
    do_op(4'd7, 16'd13);
    chk_state("push13", 16'd13, 2);
    chk("push13.valid", 32'(valid), 1);
    din = 16'd18; op = 4'd7; apply = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.head", 32'(head), 13);
      chk("hold.count", 32'(count), 2);
    end
    chk("hold.valid", 32'(valid), 1);

    // Asynchronous reset in the middle of a PUSH stream.
    op = 4'd7; din = 16'd99; apply = 1'b1;
    @(posedge clk); #1;
    chk("stream.count", 32'(count), 3);
    #2 rst = 1'b0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.head", 32'(head), 0);
    chk("arst.empty", 32'(empty), 1);
    @(posedge clk); #1;
    apply = 1'b0;
    chk("arst.hold", 32'(count), 0);
    rst = 1'b1;

    // ALU ops.
    do_op(4'd7, 16'd10);
    do_op(4'd7, 16'd3);
    do_op(4'd2, 16'd0);
    chk_state("sub", 16'd7, 1);
    do_op(4'd7, 16'd5);
    do_op(4'd1, 16'd0);
    chk_state("add", 16'd12, 1);
    do_op(4'd7, 16'h0100);
    do_op(4'd3, 16'd0);
    chk_state("mul", 16'h0C00, 1);
    do_op(4'd7, 16'h00FF);
    do_op(4'd4, 16'd0);
    chk_state("and", 16'h0000, 1);
    do_op(4'd7, 16'h0F0F);
    do_op(4'd5, 16'd0);
    chk_state("or", 16'h0F0F, 1);
    do_op(4'd7, 16'h00FF);
    do_op(4'd6, 16'd0);
    chk_state("xor", 16'h0FF0, 1);
    do_op(4'd12, 16'd0);
    chk_state("clr1", 16'd0, 0);

    // Stack manipulation.
    do_op(4'd7, 16'd1);
    do_op(4'd7, 16'd2);
    do_op(4'd10, 16'd0);
    chk_state("swap", 16'd1, 2);
    do_op(4'd11, 16'd0);
    chk_state("over", 16'd2, 3);
    do_op(4'd9, 16'd0);
    chk_state("dup", 16'd2, 4);
    chk("dup.full", 32'(full), 1);
    do_op(4'd8, 16'd0);
    chk_state("pop1", 16'd2, 3);
    do_op(4'd8, 16'd0);
    chk_state("pop2", 16'd1, 2);
    do_op(4'd8, 16'd0);
    chk_state("pop3", 16'd2, 1);
    do_op(4'd8, 16'd0);
    chk_state("pop4", 16'd0, 0);
    chk("pop4.valid", 32'(valid), 0);
    chk("pop4.empty", 32'(empty), 1);

    // Errors.
    do_op(4'd7, 16'd11);
    do_op(4'd7, 16'd22);
    do_op(4'd7, 16'd33);
    do_op(4'd7, 16'd44);
    do_op(4'd7, 16'd55);
    chk_state("ovf", 16'd44, 4);
    chk("ovf.flag", 32'(ovf), 1);
    chk("ovf.valid", 32'(valid), 0);
    do_op(4'd8, 16'd0);
    chk_state("recover", 16'd33, 3);
    chk("recover.valid", 32'(valid), 1);
    chk("recover.ovf", 32'(ovf), 1);
    do_op(4'd12, 16'd0);
    chk("clr.ovf", 32'(ovf), 0);
    do_op(4'd1, 16'd0);
    chk("udf.flag", 32'(udf), 1);
    chk("udf.count", 32'(count), 0);
    do_op(4'd14, 16'd0);
    chk("ill.udf", 32'(udf), 1);
    do_op(4'd7, 16'd5);
    chk("push5.valid", 32'(valid), 1);
    do_op(4'd13, 16'd0);
    chk_state("ill13", 16'd5, 1);
    chk("ill13.valid", 32'(valid), 0);
    do_op(4'd12, 16'd0);
    chk("clr2.ovf", 32'(ovf), 0);
    chk("clr2.udf", 32'(udf), 0);

    // Signed overflow: wrap or saturate.
    do_op(4'd7, 16'h7FFF);
    do_op(4'd7, 16'h0001);
    do_op(4'd1, 16'd0);
`ifdef STACK_ALU_SAT_EN
    chk_state("satadd", 16'h7FFF, 1);
`else
    chk_state("satadd", 16'h8000, 1);
`endif
    chk("satadd.ovf", 32'(ovf), 0);
    do_op(4'd12, 16'd0);
    do_op(4'd7, 16'h8000);
    do_op(4'd7, 16'h0001);
    do_op(4'd2, 16'd0);
`ifdef STACK_ALU_SAT_EN
    chk_state("satsub", 16'h8000, 1);
`else
    chk_state("satsub", 16'h7FFF, 1);
`endif
    chk("satsub.ovf", 32'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
